cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Shares the single common data bus (CDB) between result producers (ALU, LSB, ...).
//  Each source pushes {rob_index, value} into a private small FIFO; a round-robin scheduler
//  pops one entry per cycle and drives the registered CDB broadcast.
//  The reservation station, LSB and ROB wake up on that broadcast.
// PARAMETERS
//  NSRC        2   number of result producers (index 0 = ALU, 1 = LSB)
//  ROB_W       6   ROB index width
//  DATA_W      32  result value width
//  FIFO_DEPTH  2   entries per source FIFO (power of two, >=2)
// PORTS
//  clk            in   1             clock
//  rst            in   1             synchronous, active-high reset
//  rdy            in   1             global enable; 0 = freeze all state
//  flush          in   1             mispredict flush; discards all queued results
//  src_valid      in   NSRC          source i offers a result
//  src_rob_index  in   NSRC*ROB_W    packed ROB index, source i at [i*ROB_W +: ROB_W]
//  src_value      in   NSRC*DATA_W   packed result value
//  src_ready      out  NSRC          source i FIFO can accept this cycle
//  cdb_valid      out  1             broadcast valid
//  cdb_rob_index  out  ROB_W         broadcast ROB index
//  cdb_value      out  DATA_W        broadcast value
//  perf_grant_cnt out  NSRC*32       (CDB_ARB_PERF_EN only) grants per source
//  perf_stall_cnt out  NSRC*32       (CDB_ARB_PERF_EN only) backpressure cycles per source
// BEHAVIOUR
//  - Reset: FIFOs empty, rr_ptr=0, cdb_valid=0, cdb_rob_index=0, cdb_value=0, src_ready all 1.
//  - rdy=0: no push, no pop, all registers hold; src_ready still reflects current counts.
//  - src_ready[i] = (count[i] != FIFO_DEPTH); combinational from the registered count only.
//    A full FIFO does not accept, even in a cycle where it is popped.
//  - Push: at an edge with rdy & ~flush & src_valid[i] & src_ready[i].
//  - Pop/grant, per edge (rdy & ~flush):
//    - Search nonempty FIFOs starting at rr_ptr, ascending and wrapping mod NSRC.
//    - First hit w: pop head of w; cdb_* <= head; cdb_valid <= 1; rr_ptr <= (w+1) mod NSRC.
//    - No hit: cdb_valid <= 0; cdb_rob_index/value hold; rr_ptr holds.
//  - Latency: entry pushed at edge N into an uncontested empty FIFO is on the CDB after edge N+1.
//    cdb_valid is a one-cycle pulse per entry.
//  - Same FIFO pushed and popped on one edge: count unchanged, order preserved (FIFO per source).
//  - Throughput: one broadcast per cycle. A source never waits more than NSRC-1 grants once at the
//    head of its FIFO.
//  - Flush (rdy=1): next edge empties all FIFOs and sets cdb_valid <= 0; that cycle's src_valid is ignored.
//    rr_ptr holds. Entries queued before the flush are never broadcast.
//  - rst has priority over flush; rst mid-stream drops all queued entries.
//  - FIFO pointers wrap mod FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.
// CONFIGURATION
//  CDB_ARB_PERF_EN defined:
//    - perf_grant_cnt[i] += 1 on each grant to i.
//    - perf_stall_cnt[i] += 1 each rdy cycle with src_valid[i] & ~src_ready[i].
//    - 32-bit counters wrap mod 2^32; cleared by rst only, not by flush.
//  CDB_ARB_PERF_EN undefined: perf ports and counters absent; all other behaviour identical.
// STRUCTURE
//  - Shared header cpu_defs: ROB_W, DATA_W, CDB source index constants (CDB_SRC_ALU=0, CDB_SRC_LSB=1).
//  - Sub-module cdb_src_fifo: one per source via generate.
//    - Ports: clk, rst, rdy, flush, push, din, pop, dout, count.
//  - Round-robin pick and output registers live in cdb_arbiter.
// TESTING
//  1 Single push, src0 rob=5 value=0x0000_1234 at edge 1
//    -> after edge 2: cdb_valid=1, rob=5, value=0x1234; after edge 3: cdb_valid=0.
//  2 Both sources push every cycle, rob 0,2,4.. / 1,3,5..
//    -> grants alternate src0,src1,src0..; every rob broadcast once, in order per source.
//  3 src1 holds valid while src0 streams, FIFO_DEPTH=2
//    -> src_ready[1]=0 once count[1]=2; reasserts the cycle after src1 is granted; no loss, no duplicate.
//  4 Queue 2 entries on src0 and 1 on src1, assert flush one cycle
//    -> next cycle cdb_valid=0 and src_ready=2'b11; none of the 3 robs ever appears on the CDB.
//  5 rdy=0 for 3 cycles mid-stream
//    -> cdb_* and counts frozen; after rdy=1 the sequence continues identically to a no-stall run.
//  6 CDB_ARB_PERF_EN, src1 blocked for 4 cycles, then 3 grants
//    -> perf_stall_cnt[1]=4, perf_grant_cnt[1]=3; both counters unchanged by a following flush.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared CPU definitions for the CDB arbiter: ROB/result widths, CDB source indices
// and the round-robin successor helper.
package cdb_arbiter_pkg;

   localparam int CPU_ROB_W   = 6;
   localparam int CPU_DATA_W  = 32;
   localparam int CDB_NSRC    = 2;
   localparam int CDB_SRC_ALU = 0;
   localparam int CDB_SRC_LSB = 1;

   function automatic int rr_next(input int idx, input int n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO feeding the CDB arbiter; rdy freezes it, flush empties it.
// Caller guarantees push only when not full and pop only when not empty.
module cdb_src_fifo
   import cdb_arbiter_pkg::*;
#(
   parameter int W     = CPU_ROB_W + CPU_DATA_W,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rdy,
   input  logic                       flush,
   input  logic                       push,
   input  logic [W-1:0]               din,
   input  logic                       pop,
   output logic [W-1:0]               dout,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (rdy) begin
         if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
         end else begin
            if (push) begin
               mem_d[wr_ptr_q] = din;
               wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
               2'b10:   count_d = count_q + CNT_W'(1);
               2'b01:   count_d = count_q - CNT_W'(1);
               default: count_d = count_q;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries data only; emptiness is tracked by count_q, so it needs no reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the registered CDB broadcast among per-source FIFOs.
// Optional CDB_ARB_PERF_EN adds per-source grant and backpressure counters.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NSRC       = CDB_NSRC,
   parameter int ROB_W      = CPU_ROB_W,
   parameter int DATA_W     = CPU_DATA_W,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rdy,
   input  logic                     flush,
   input  logic [NSRC-1:0]          src_valid,
   input  logic [NSRC*ROB_W-1:0]    src_rob_index,
   input  logic [NSRC*DATA_W-1:0]   src_value,
   output logic [NSRC-1:0]          src_ready,
   output logic                     cdb_valid,
   output logic [ROB_W-1:0]         cdb_rob_index,
   output logic [DATA_W-1:0]        cdb_value
`ifdef CDB_ARB_PERF_EN
   ,
   output logic [NSRC*32-1:0]       perf_grant_cnt,
   output logic [NSRC*32-1:0]       perf_stall_cnt
`endif
);

   localparam int ENT_W = ROB_W + DATA_W;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int PTR_W = (NSRC > 1) ? $clog2(NSRC) : 1;

   logic [NSRC-1:0]   push;
   logic [NSRC-1:0]   pop;
   logic [NSRC-1:0]   nonempty;
   logic [ENT_W-1:0]  head  [NSRC];
   logic [CNT_W-1:0]  count [NSRC];

   logic              grant_found;
   logic [PTR_W-1:0]  grant_idx;
   logic [PTR_W-1:0]  cand;

   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic              cdb_valid_q, cdb_valid_d;
   logic [ROB_W-1:0]  cdb_rob_index_q, cdb_rob_index_d;
   logic [DATA_W-1:0] cdb_value_q, cdb_value_d;

   // Ready looks only at the registered count: a full FIFO refuses even while being popped.
   for (genvar i = 0; i < NSRC; i++) begin : g_src
      assign nonempty[i]  = (count[i] != '0);
      assign src_ready[i] = (count[i] != CNT_W'(FIFO_DEPTH));
      assign push[i]      = rdy & ~flush & src_valid[i] & src_ready[i];
      assign pop[i]       = rdy & ~flush & grant_found & (grant_idx == PTR_W'(i));

      cdb_src_fifo #(
         .W     (ENT_W),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .rdy   (rdy),
         .flush (flush),
         .push  (push[i]),
         .din   ({src_rob_index[i*ROB_W +: ROB_W], src_value[i*DATA_W +: DATA_W]}),
         .pop   (pop[i]),
         .dout  (head[i]),
         .count (count[i])
      );
   end

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 0; k < NSRC; k++) begin
         cand = PTR_W'((int'(rr_ptr_q) + k) % NSRC);
         if (!grant_found && nonempty[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_comb begin
      rr_ptr_d        = rr_ptr_q;
      cdb_valid_d     = cdb_valid_q;
      cdb_rob_index_d = cdb_rob_index_q;
      cdb_value_d     = cdb_value_q;
      if (rdy) begin
         if (flush) begin
            cdb_valid_d = 1'b0;
         end else if (grant_found) begin
            cdb_valid_d                    = 1'b1;
            {cdb_rob_index_d, cdb_value_d} = head[grant_idx];
            rr_ptr_d                       = PTR_W'(rr_next(int'(grant_idx), NSRC));
         end else begin
            cdb_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q        <= '0;
         cdb_valid_q     <= 1'b0;
         cdb_rob_index_q <= '0;
         cdb_value_q     <= '0;
      end else begin
         rr_ptr_q        <= rr_ptr_d;
         cdb_valid_q     <= cdb_valid_d;
         cdb_rob_index_q <= cdb_rob_index_d;
         cdb_value_q     <= cdb_value_d;
      end
   end

   assign cdb_valid     = cdb_valid_q;
   assign cdb_rob_index = cdb_rob_index_q;
   assign cdb_value     = cdb_value_q;

`ifdef CDB_ARB_PERF_EN
   // Counters survive flush; only rst clears them.
   logic [31:0] grant_cnt_q [NSRC];
   logic [31:0] grant_cnt_d [NSRC];
   logic [31:0] stall_cnt_q [NSRC];
   logic [31:0] stall_cnt_d [NSRC];

   always_comb begin
      for (int i = 0; i < NSRC; i++) begin
         grant_cnt_d[i] = grant_cnt_q[i] + 32'(pop[i]);
         stall_cnt_d[i] = stall_cnt_q[i] + 32'(rdy & src_valid[i] & ~src_ready[i]);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NSRC; i++) begin
         if (rst) begin
            grant_cnt_q[i] <= '0;
            stall_cnt_q[i] <= '0;
         end else begin
            grant_cnt_q[i] <= grant_cnt_d[i];
            stall_cnt_q[i] <= stall_cnt_d[i];
         end
      end
   end

   for (genvar i = 0; i < NSRC; i++) begin : g_perf
      assign perf_grant_cnt[i*32 +: 32] = grant_cnt_q[i];
      assign perf_stall_cnt[i*32 +: 32] = stall_cnt_q[i];
   end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (NSRC=2, FIFO_DEPTH=2).
// Perf-counter scenario is compiled only when CDB_ARB_PERF_EN is defined.
module tb_cdb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        flush;
   logic [1:0]  src_valid;
   logic [11:0] src_rob_index;
   logic [63:0] src_value;
   logic [1:0]  src_ready;
   logic        cdb_valid;
   logic [5:0]  cdb_rob_index;
   logic [31:0] cdb_value;
`ifdef CDB_ARB_PERF_EN
   logic [63:0] perf_grant_cnt;
   logic [63:0] perf_stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cdb_arbiter dut (
      .clk           (clk),
      .rst           (rst),
      .rdy           (rdy),
      .flush         (flush),
      .src_valid     (src_valid),
      .src_rob_index (src_rob_index),
      .src_value     (src_value),
      .src_ready     (src_ready),
      .cdb_valid     (cdb_valid),
      .cdb_rob_index (cdb_rob_index),
      .cdb_value     (cdb_value)
`ifdef CDB_ARB_PERF_EN
      ,
      .perf_grant_cnt(perf_grant_cnt),
      .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offered value is always rob + 0x100 so the value field is checkable from the rob.
   task automatic drive(input bit v0, input int r0, input bit v1, input int r1);
      src_valid     = {v1, v0};
      src_rob_index = {6'(r1), 6'(r0)};
      src_value     = {32'(r1 + 'h100), 32'(r0 + 'h100)};
   endtask

   task automatic do_reset();
      rst = 1'b1; rdy = 1'b1; flush = 1'b0;
      drive(0, 0, 0, 0);
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; rdy = 1'b1; flush = 1'b0;
      drive(1, 7, 1, 9);
      step(); step();
      rst = 1'b0;
      drive(0, 0, 0, 0);
      checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", cdb_valid); end
      checks++; if (cdb_rob_index !== 6'd0) begin errors++; $display("FAIL reset_rob got %0d want 0", cdb_rob_index); end
      checks++; if (cdb_value !== 32'd0) begin errors++; $display("FAIL reset_value got %h want 0", cdb_value); end
      checks++; if (src_ready !== 2'b11) begin errors++; $display("FAIL reset_ready got %b want 11", src_ready); end
   endtask

   task automatic test_single_push();
      do_reset();
      drive(1, 5, 0, 0);
      src_value[31:0] = 32'h0000_1234;
      step();
      drive(0, 0, 0, 0);
      checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL single_e1_valid got %0b want 0", cdb_valid); end
      step();
      checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL single_e2_valid got %0b want 1", cdb_valid); end
      checks++; if (cdb_rob_index !== 6'd5) begin errors++; $display("FAIL single_e2_rob got %0d want 5", cdb_rob_index); end
      checks++; if (cdb_value !== 32'h0000_1234) begin errors++; $display("FAIL single_e2_value got %h want 00001234", cdb_value); end
      step();
      checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL single_e3_valid got %0b want 0", cdb_valid); end
   endtask

   // Both sources stream with handshake; grants must alternate and each rob appear once, in order.
   task automatic test_round_robin();
      int cur[2];
      int expr[2];
      int prev_src;
      int src;
      int bcast;
      int accepted;
      logic [1:0] acc;
      do_reset();
      cur[0] = 0; cur[1] = 1; expr[0] = 0; expr[1] = 1;
      prev_src = 1; bcast = 0; accepted = 0;
      for (int c = 0; c < 16; c++) begin
         if (c < 10) drive(1, cur[0], 1, cur[1]);
         else        drive(0, 0, 0, 0);
         acc = src_valid & src_ready;
         step();
         for (int i = 0; i < 2; i++) if (acc[i]) begin cur[i] += 2; accepted++; end
         if (cdb_valid === 1'b1) begin
            src = int'(cdb_rob_index[0]);
            checks++;
            if (cdb_rob_index !== 6'(expr[src]) || cdb_value !== 32'(expr[src] + 'h100)) begin
               errors++;
               $display("FAIL rr_order got rob %0d value %h want rob %0d value %h",
                        cdb_rob_index, cdb_value, expr[src], 32'(expr[src] + 'h100));
            end
            checks++;
            if (src == prev_src) begin errors++; $display("FAIL rr_alternate got src %0d twice want alternation", src); end
            expr[src] += 2;
            prev_src = src;
            bcast++;
         end
      end
      checks++;
      if (bcast != accepted || bcast != 12) begin
         errors++;
         $display("FAIL rr_count got %0d broadcasts want %0d (accepted %0d)", bcast, 12, accepted);
      end
   endtask

   task automatic test_backpressure();
      int v0[9] = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
      int r0[9] = '{10, 12, 14, 16, 16, 0, 0, 0, 0};
      int v1[9] = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
      int r1[9] = '{11, 13, 15, 15, 17, 0, 0, 0, 0};
      int ev[9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
      int er[9] = '{0, 10, 11, 12, 13, 14, 15, 16, 16};
      logic [1:0] erdy[9] = '{2'b11, 2'b01, 2'b10, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
      logic [31:0] eval;
      do_reset();
      for (int k = 0; k < 9; k++) begin
         drive(v0[k] != 0, r0[k], v1[k] != 0, r1[k]);
         step();
         eval = (er[k] == 0) ? 32'd0 : 32'(er[k] + 'h100);
         checks++;
         if (cdb_valid !== 1'(ev[k]) || cdb_rob_index !== 6'(er[k]) || cdb_value !== eval) begin
            errors++;
            $display("FAIL bp_cdb edge %0d got v%0b rob %0d val %h want v%0d rob %0d val %h",
                     k + 1, cdb_valid, cdb_rob_index, cdb_value, ev[k], er[k], eval);
         end
         checks++;
         if (src_ready !== erdy[k]) begin
            errors++;
            $display("FAIL bp_ready edge %0d got %b want %b", k + 1, src_ready, erdy[k]);
         end
      end
      drive(0, 0, 0, 0);
   endtask

   task automatic test_flush();
      do_reset();
      drive(1, 20, 1, 21);
      step();
      checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_pre_valid got %0b want 0", cdb_valid); end
      flush = 1'b1;
      drive(1, 22, 0, 0);
      step();
      flush = 1'b0;
      drive(0, 0, 0, 0);
      checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", cdb_valid); end
      checks++; if (src_ready !== 2'b11) begin errors++; $display("FAIL flush_ready got %b want 11", src_ready); end
      for (int c = 0; c < 4; c++) begin
         step();
         checks++;
         if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_leak cycle %0d got rob %0d valid %0b want no broadcast", c, cdb_rob_index, cdb_valid);
         end
      end
      drive(0, 0, 1, 23);
      step();
      drive(0, 0, 0, 0);
      step();
      checks++;
      if (cdb_valid !== 1'b1 || cdb_rob_index !== 6'd23) begin
         errors++;
         $display("FAIL flush_after got v%0b rob %0d want v1 rob 23", cdb_valid, cdb_rob_index);
      end
   endtask

   task automatic test_rdy_stall();
      int rd[12] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
      int v0[12] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
      int r0[12] = '{10, 12, 14, 16, 16, 16, 16, 16, 0, 0, 0, 0};
      int v1[12] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
      int r1[12] = '{11, 13, 15, 15, 15, 15, 15, 17, 0, 0, 0, 0};
      int ev[12] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
      int er[12] = '{0, 10, 11, 11, 11, 11, 12, 13, 14, 15, 16, 16};
      logic [1:0] erdy[12] = '{2'b11, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10,
                              2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
      do_reset();
      for (int k = 0; k < 12; k++) begin
         rdy = 1'(rd[k]);
         drive(v0[k] != 0, r0[k], v1[k] != 0, r1[k]);
         step();
         checks++;
         if (cdb_valid !== 1'(ev[k]) || cdb_rob_index !== 6'(er[k]) || src_ready !== erdy[k]) begin
            errors++;
            $display("FAIL stall edge %0d got v%0b rob %0d rdy %b want v%0d rob %0d rdy %b",
                     k + 1, cdb_valid, cdb_rob_index, src_ready, ev[k], er[k], erdy[k]);
         end
      end
      rdy = 1'b1;
      drive(0, 0, 0, 0);
   endtask

   task automatic test_reset_midstream();
      do_reset();
      drive(1, 30, 1, 31);
      step();
      rst = 1'b1;
      drive(0, 0, 0, 0);
      step();
      rst = 1'b0;
      checks++;
      if (cdb_valid !== 1'b0 || src_ready !== 2'b11) begin
         errors++;
         $display("FAIL midrst got v%0b rdy %b want v0 rdy 11", cdb_valid, src_ready);
      end
      step(); step();
      checks++;
      if (cdb_valid !== 1'b0) begin
         errors++;
         $display("FAIL midrst_drop got rob %0d valid %0b want no broadcast", cdb_rob_index, cdb_valid);
      end
   endtask

`ifdef CDB_ARB_PERF_EN
   task automatic test_perf();
      int cur[2];
      logic [1:0] acc;
      do_reset();
      cur[0] = 0; cur[1] = 1;
      for (int c = 0; c < 13; c++) begin
         if (c < 9) drive(1, cur[0], 1, cur[1]);
         else       drive(0, 0, 0, 0);
         acc = src_valid & src_ready;
         step();
         for (int i = 0; i < 2; i++) if (acc[i]) cur[i] += 2;
      end
      checks++; if (perf_stall_cnt[63:32] !== 32'd4) begin errors++; $display("FAIL perf_stall1 got %0d want 4", perf_stall_cnt[63:32]); end
      checks++; if (perf_stall_cnt[31:0] !== 32'd3) begin errors++; $display("FAIL perf_stall0 got %0d want 3", perf_stall_cnt[31:0]); end
      checks++; if (perf_grant_cnt[63:32] !== 32'd5) begin errors++; $display("FAIL perf_grant1 got %0d want 5", perf_grant_cnt[63:32]); end
      checks++; if (perf_grant_cnt[31:0] !== 32'd6) begin errors++; $display("FAIL perf_grant0 got %0d want 6", perf_grant_cnt[31:0]); end
      flush = 1'b1;
      drive(1, 40, 1, 41);
      step();
      flush = 1'b0;
      drive(0, 0, 0, 0);
      step();
      checks++;
      if (perf_stall_cnt !== {32'd4, 32'd3} || perf_grant_cnt !== {32'd5, 32'd6}) begin
         errors++;
         $display("FAIL perf_flush got grant %h stall %h want grant 0000000500000006 stall 0000000400000003",
                  perf_grant_cnt, perf_stall_cnt);
      end
   endtask
`endif

   initial begin
      rst = 1'b1; rdy = 1'b1; flush = 1'b0;
      drive(0, 0, 0, 0);
      test_reset();
      test_single_push();
      test_round_robin();
      test_backpressure();
      test_flush();
      test_rdy_stall();
      test_reset_midstream();
`ifdef CDB_ARB_PERF_EN
      test_perf();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
